// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between fetch (read-only) and data (read/write).
// One access at a time; all outputs except the stalls are registered.
module mem_port_arbiter #(
  parameter int LAT          = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        if_stall,
  output logic        dm_stall
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int RW = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

  state_t        state_q, state_d;
  logic          own_dm_q, own_dm_d;
  logic          acc_wr_q, acc_wr_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [RW-1:0] run_q, run_d;
  logic          mem_en_d, mem_wr_d, if_done_d, dm_done_d;
  logic [15:0]   mem_addr_d, mem_wdata_d, if_rdata_d, dm_rdata_d;
  logic          pick_if;
  mem_req_t      sel;

  // Fetch only overrides a pending data request once the data run is exhausted.
  assign pick_if = if_req & (~dm_req | (run_q == RW'(MAX_DATA_RUN)));

  always_comb begin
    sel.wr    = pick_if ? 1'b0 : dm_wr;
    sel.addr  = pick_if ? if_addr : dm_addr;
    sel.wdata = pick_if ? mem_wdata : dm_wdata;
  end

  always_comb begin
    state_d     = state_q;
    own_dm_d    = own_dm_q;
    acc_wr_d    = acc_wr_q;
    wcnt_d      = wcnt_q;
    run_d       = run_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    case (state_q)
      S_IDLE: begin
        if (!if_req) run_d = '0;
        if (if_req || dm_req) begin
          state_d     = S_GRANT;
          mem_en_d    = 1'b1;
          mem_wr_d    = sel.wr;
          mem_addr_d  = sel.addr;
          mem_wdata_d = sel.wdata;
          acc_wr_d    = sel.wr;
          own_dm_d    = ~pick_if;
          if (pick_if)     run_d = '0;
          else if (if_req) run_d = run_q + 1'b1;
        end
      end
      S_GRANT: begin
        wcnt_d  = CW'(LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = S_DONE;
          if (own_dm_q) begin
            dm_done_d  = 1'b1;
            dm_rdata_d = acc_wr_q ? 16'h0000 : mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      own_dm_q  <= 1'b0;
      acc_wr_q  <= 1'b0;
      wcnt_q    <= '0;
      run_q     <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= 16'h0000;
      dm_rdata  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      own_dm_q  <= own_dm_d;
      acc_wr_q  <= acc_wr_d;
      wcnt_q    <= wcnt_d;
      run_q     <= run_d;
      mem_en    <= mem_en_d;
      mem_wr    <= mem_wr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_done   <= if_done_d;
      dm_done   <= dm_done_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, write path, arbitration order,
// data-run fairness, reset abandon and address hold.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        mem_en, mem_wr, if_done, dm_done, if_stall, dm_stall;
  logic [15:0] mem_addr, mem_wdata, if_rdata, dm_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.LAT(2), .MAX_DATA_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .if_stall(if_stall), .dm_stall(dm_stall)
  );

  always #5 clk = ~clk;

  // Memory model: data valid only exactly LAT=2 cycles after mem_en, garbage otherwise.
  logic en_d1 = 1'b0, en_d2 = 1'b0;
  always @(posedge clk) begin
    en_d1 <= mem_en;
    en_d2 <= en_d1;
  end
  assign mem_rdata = en_d2 ? (mem_addr ^ 16'hA5B5) : 16'hDEAD;

  // Protocol monitor: grant log (1 = data address), done counts, rule violations.
  logic [15:0] grant_log = '0;
  int n_grant = 0, n_if = 0, n_dm = 0, viol = 0;
  logic en_prev = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      en_prev <= 1'b0;
    end else begin
      en_prev <= mem_en;
      if (mem_en) begin
        grant_log <= {grant_log[14:0], mem_addr[8]};
        n_grant   <= n_grant + 1;
      end
      if (if_done) n_if <= n_if + 1;
      if (dm_done) n_dm <= n_dm + 1;
      if ((mem_wr && !mem_en) || (if_done && dm_done) || (mem_en && en_prev))
        viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int b_if, b_dm, b_gr;

  initial begin
    rst = 1'b1; if_req = 0; dm_req = 0; dm_wr = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    cyc(3);
    check("rst_mem_en", 16'(mem_en), 16'd0);
    check("rst_mem_wr", 16'(mem_wr), 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_dones", {14'd0, if_done, dm_done}, 16'd0);
    check("rst_rdata", if_rdata | dm_rdata, 16'h0000);
    rst = 1'b0;
    cyc(1);

    // Fetch only: mem_en at cycle 1, done at cycle 4
    if_req = 1; if_addr = 16'h0010; #1;
    check("t1_c0_stall", 16'(if_stall), 16'd1);
    check("t1_c0_en", 16'(mem_en), 16'd0);
    cyc(1);
    check("t1_c1_en", 16'(mem_en), 16'd1);
    check("t1_c1_wr", 16'(mem_wr), 16'd0);
    check("t1_c1_addr", mem_addr, 16'h0010);
    check("t1_c1_stall", 16'(if_stall), 16'd1);
    cyc(1);
    check("t1_c2_en", 16'(mem_en), 16'd0);
    cyc(1);
    check("t1_c3_done", 16'(if_done), 16'd0);
    check("t1_c3_stall", 16'(if_stall), 16'd1);
    cyc(1);
    check("t1_c4_done", 16'(if_done), 16'd1);
    check("t1_c4_rdata", if_rdata, 16'hA5A5);
    check("t1_c4_stall", 16'(if_stall), 16'd0);
    check("t1_c4_dmdone", 16'(dm_done), 16'd0);
    if_req = 0;
    cyc(1);
    check("t1_c5_done", 16'(if_done), 16'd0);

    // Data write; dm_addr changes during WAIT must not leak to mem_addr
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'h1234; #1;
    check("t2_c0_stall", 16'(dm_stall), 16'd1);
    cyc(1);
    check("t2_c1_en", 16'(mem_en), 16'd1);
    check("t2_c1_wr", 16'(mem_wr), 16'd1);
    check("t2_c1_addr", mem_addr, 16'h0100);
    check("t2_c1_wdata", mem_wdata, 16'h1234);
    cyc(1);
    check("t2_c2_en", 16'(mem_en), 16'd0);
    check("t2_c2_wr", 16'(mem_wr), 16'd0);
    dm_addr = 16'h0200; dm_wdata = 16'hFFFF;
    cyc(1);
    check("t2_c3_addr_hold", mem_addr, 16'h0100);
    check("t2_c3_wdata_hold", mem_wdata, 16'h1234);
    check("t2_c3_done", 16'(dm_done), 16'd0);
    cyc(1);
    check("t2_c4_done", 16'(dm_done), 16'd1);
    check("t2_c4_rdata", dm_rdata, 16'h0000);
    check("t2_c4_ifdone", 16'(if_done), 16'd0);
    check("t2_c4_stall", 16'(dm_stall), 16'd0);
    dm_req = 0; dm_wr = 0;
    cyc(1);
    check("t2_c5_done", 16'(dm_done), 16'd0);

    // Simultaneous requests: data first, fetch on the next IDLE
    b_if = n_if; b_dm = n_dm;
    if_req = 1; if_addr = 16'h0020; dm_req = 1; dm_wr = 0; dm_addr = 16'h0130;
    cyc(1);
    check("t3_c1_addr", mem_addr, 16'h0130);
    check("t3_c1_en", 16'(mem_en), 16'd1);
    cyc(3);
    check("t3_c4_dmdone", 16'(dm_done), 16'd1);
    check("t3_c4_dmrdata", dm_rdata, 16'hA485);
    check("t3_c4_ifdone", 16'(if_done), 16'd0);
    check("t3_c4_ifstall", 16'(if_stall), 16'd1);
    dm_req = 0;
    cyc(2);
    check("t3_c6_en", 16'(mem_en), 16'd1);
    check("t3_c6_addr", mem_addr, 16'h0020);
    cyc(3);
    check("t3_c9_ifdone", 16'(if_done), 16'd1);
    check("t3_c9_ifrdata", if_rdata, 16'hA595);
    check("t3_c9_dmdone", 16'(dm_done), 16'd0);
    check("t3_c9_dmrdata_hold", dm_rdata, 16'hA485);
    if_req = 0;
    cyc(1);
    check("t3_n_if", 16'(n_if - b_if), 16'd1);
    check("t3_n_dm", 16'(n_dm - b_dm), 16'd1);

    // Both held for 10 accesses: D D D D F D D D D F
    b_if = n_if; b_dm = n_dm; b_gr = n_grant;
    if_req = 1; if_addr = 16'h0040; dm_req = 1; dm_wr = 0; dm_addr = 16'h0150;
    cyc(50);
    if_req = 0; dm_req = 0;
    cyc(3);
    check("t4_grants", 16'(n_grant - b_gr), 16'd10);
    check("t4_order", {6'd0, grant_log[9:0]}, 16'b0000_0011_1101_1110);
    check("t4_n_if", 16'(n_if - b_if), 16'd2);
    check("t4_n_dm", 16'(n_dm - b_dm), 16'd8);

    // Reset during WAIT abandons the access; the held request restarts cleanly
    b_dm = n_dm;
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0160;
    cyc(1);
    check("t5_c1_addr", mem_addr, 16'h0160);
    cyc(1);
    rst = 1;
    cyc(1);
    check("t5_rst_en", 16'(mem_en), 16'd0);
    check("t5_rst_addr", mem_addr, 16'h0000);
    check("t5_rst_rdata", dm_rdata | if_rdata, 16'h0000);
    check("t5_rst_done", {14'd0, if_done, dm_done}, 16'd0);
    rst = 0;
    cyc(1);
    check("t5_n1_en", 16'(mem_en), 16'd1);
    check("t5_n1_addr", mem_addr, 16'h0160);
    check("t5_n1_done", 16'(dm_done), 16'd0);
    cyc(3);
    check("t5_n4_done", 16'(dm_done), 16'd1);
    check("t5_n4_rdata", dm_rdata, 16'hA4D5);
    dm_req = 0;
    cyc(1);
    check("t5_n_dm", 16'(n_dm - b_dm), 16'd1);
    check("protocol_viol", 16'(viol), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
